cpu_mult_seq: RTL and testbench

Parametrised sequential integer multiplier for the CPU execute stage. It is the successor to the fixed 32x32 low-half multiplier cell.
- Supports any DATA_W that is a multiple of 16.
- Supports signed and unsigned operands independently, and selects the high or low half of the 2*DATA_W product.
- Uses a valid/ready handshake with a destination tag.
- Time-multiplexes a single registered 16x16 unsigned multiplier over all partial products.

---
 rtl/cpu_mult_pkg.sv | 19 +
 rtl/cpu_mult_pp16.sv | 21 ++
 rtl/cpu_mult_seq.sv | 129 ++++++++++++
 tb/tb_cpu_mult_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mult_pkg.sv
// Shared types and helpers for the sequential CPU multiplier.
// The partial-product width is fixed at 16 to match the DSP multiplier primitive.
package cpu_mult_pkg;

   localparam int PP_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      CORR = 2'd2,
      DONE = 2'd3
   } state_t;

   // Bit offset of partial product i: A chunk index is i mod n, B chunk index is i div n
   function automatic int pp_shift(input int i, input int n);
      return PP_W * ((i % n) + (i / n));
   endfunction

endpackage

// File: rtl/cpu_mult_pp16.sv
// Registered 16x16 -> 32 unsigned multiplier; this is the only place the DSP block is inferred.
module cpu_mult_pp16
   import cpu_mult_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [PP_W-1:0]   a,
   input  logic [PP_W-1:0]   b,
   output logic [2*PP_W-1:0] p
);

   always_ff @(posedge clk) begin
      if (reset) begin
         p <= '0;
      end else if (en) begin
         p <= a * b;
      end
   end

endmodule

// File: rtl/cpu_mult_seq.sv
// Sequential signed/unsigned integer multiplier that time-multiplexes one 16x16 multiplier.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module cpu_mult_seq
   import cpu_mult_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_signed_a,
   input  logic              in_signed_b,
   input  logic              in_hi,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int N     = DATA_W / PP_W;
   localparam int NPP   = N * N;
   localparam int CNT_W = $clog2(NPP + 1);
   localparam int W2    = 2 * DATA_W;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   a_q, b_q;
   logic                sa_q, sb_q, hi_q;
   logic [TAG_W-1:0]    tag_q;
   logic [W2-1:0]       acc_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                issue_en, acc_en, last_cnt;
   int                  issue_i, prev_i;
   logic [PP_W-1:0]     mul_a, mul_b;
   logic [2*PP_W-1:0]   pp;
   logic [W2-1:0]       pp_ext, corr;

   assign in_ready = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign last_cnt = (cnt_q == CNT_W'(NPP));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = MUL;
         MUL:     if (last_cnt) state_d = CORR;
         CORR:    state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // cnt_q counts MUL cycles; the product issued at count k is accumulated at count k+1
   always_comb begin
      issue_en = (state_q == MUL) && (int'(cnt_q) < NPP);
      acc_en   = (state_q == MUL) && (cnt_q != '0);
      issue_i  = issue_en ? int'(cnt_q) : 0;
      prev_i   = (cnt_q == '0) ? 0 : int'(cnt_q) - 1;
      mul_a    = a_q[(issue_i % N)*PP_W +: PP_W];
      mul_b    = b_q[(issue_i / N)*PP_W +: PP_W];
      pp_ext   = W2'(pp) << pp_shift(prev_i, N);
      corr     = acc_q
               - ((sa_q && a_q[DATA_W-1]) ? {b_q, {DATA_W{1'b0}}} : '0)
               - ((sb_q && b_q[DATA_W-1]) ? {a_q, {DATA_W{1'b0}}} : '0);
   end

   cpu_mult_pp16 u_pp (
      .clk   (clk),
      .reset (reset),
      .en    (issue_en),
      .a     (mul_a),
      .b     (mul_b),
      .p     (pp)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q        <= '0;
         b_q        <= '0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         hi_q       <= 1'b0;
         tag_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         out_result <= '0;
         out_tag    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= in_a;
                  b_q   <= in_b;
                  sa_q  <= in_signed_a;
                  sb_q  <= in_signed_b;
                  hi_q  <= in_hi;
                  tag_q <= in_tag;
                  acc_q <= '0;
                  cnt_q <= '0;
               end
            end
            MUL: begin
               if (!last_cnt) cnt_q <= cnt_q + 1'b1;
               if (acc_en) acc_q <= acc_q + pp_ext;
            end
            CORR: begin
               acc_q      <= corr;
               out_result <= hi_q ? corr[W2-1:DATA_W] : corr[DATA_W-1:0];
               out_tag    <= tag_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_mult_seq.sv
// Self-checking bench for cpu_mult_seq at DATA_W = 32, 16 and 64 with a queued reference model.
module tb_cpu_mult_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] a_s, b_s;
   logic        sa_s, sb_s, hi_s, ordy;
   logic [4:0]  tag_s;
   logic        iv   [3];
   logic        rdy  [3];
   logic        ov   [3];
   logic [4:0]  tg   [3];
   logic [63:0] res  [3];
   logic [31:0] r32;
   logic [15:0] r16;
   logic [63:0] r64;

   logic [63:0] exp_q[$];
   logic [4:0]  exp_tag_q[$];
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   cpu_mult_seq #(.DATA_W(32), .TAG_W(5)) dut32 (
      .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(rdy[0]),
      .in_a(a_s[31:0]), .in_b(b_s[31:0]), .in_signed_a(sa_s), .in_signed_b(sb_s),
      .in_hi(hi_s), .in_tag(tag_s), .out_valid(ov[0]), .out_ready(ordy),
      .out_result(r32), .out_tag(tg[0])
   );

   cpu_mult_seq #(.DATA_W(16), .TAG_W(5)) dut16 (
      .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
      .in_a(a_s[15:0]), .in_b(b_s[15:0]), .in_signed_a(sa_s), .in_signed_b(sb_s),
      .in_hi(hi_s), .in_tag(tag_s), .out_valid(ov[1]), .out_ready(ordy),
      .out_result(r16), .out_tag(tg[1])
   );

   cpu_mult_seq #(.DATA_W(64), .TAG_W(5)) dut64 (
      .clk(clk), .reset(rst), .in_valid(iv[2]), .in_ready(rdy[2]),
      .in_a(a_s), .in_b(b_s), .in_signed_a(sa_s), .in_signed_b(sb_s),
      .in_hi(hi_s), .in_tag(tag_s), .out_valid(ov[2]), .out_ready(ordy),
      .out_result(r64), .out_tag(tg[2])
   );

   assign res[0] = {32'd0, r32};
   assign res[1] = {48'd0, r16};
   assign res[2] = r64;

   // Reference: sign-extend to 128 bits, multiply, pick the requested half
   function automatic logic [63:0] ref_mult(input logic [63:0] a, input logic [63:0] b,
                                            input logic sa, input logic sb,
                                            input logic hi, input int w);
      logic [127:0] mask, ea, eb, p;
      mask = (128'd1 << w) - 128'd1;
      ea = {64'd0, a} & mask;
      eb = {64'd0, b} & mask;
      if (sa && a[w-1]) ea = ea | ~mask;
      if (sb && b[w-1]) eb = eb | ~mask;
      p = ea * eb;
      return hi ? 64'((p >> w) & mask) : 64'(p & mask);
   endfunction

   task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", nm, obs, expv);
   endtask

   // Latency is the cycle index of the first out_valid cycle, the accepting cycle being 0
   task automatic do_op(input int k, input logic [63:0] a, input logic [63:0] b,
                        input logic sa, input logic sb, input logic hi,
                        input logic [4:0] tag, input int stall);
      int w, npp, t, n;
      logic [63:0] e_res;
      logic [4:0]  e_tag;
      w   = (k == 0) ? 32 : (k == 1) ? 16 : 64;
      npp = (w / 16) * (w / 16);
      exp_q.push_back(ref_mult(a, b, sa, sb, hi, w));
      exp_tag_q.push_back(tag);
      @(negedge clk);
      a_s = a; b_s = b; sa_s = sa; sb_s = sb; hi_s = hi; tag_s = tag;
      ordy = (stall == 0);
      iv[k] = 1'b1;
      t = 0;
      while (!rdy[k] && t < 100) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      iv[k] = 1'b0;
      a_s = {$urandom, $urandom}; b_s = {$urandom, $urandom};
      sa_s = ~sa; sb_s = ~sb; hi_s = ~hi; tag_s = ~tag;
      n = 0;
      while (!ov[k] && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", 64'(n + 1), 64'(npp + 3));
      e_res = exp_q.pop_front();
      e_tag = exp_tag_q.pop_front();
      check("result", res[k], e_res);
      check("tag", 64'(tg[k]), 64'(e_tag));
      for (int j = 0; j < stall; j++) begin
         @(negedge clk);
         iv[k] = (j == 2);
         tag_s = 5'h1f;
         @(posedge clk);
         #1;
         check("stall_valid", 64'(ov[k]), 64'd1);
         check("stall_result", res[k], e_res);
         check("stall_tag", 64'(tg[k]), 64'(e_tag));
         check("stall_in_ready", 64'(rdy[k]), 64'd0);
      end
      @(negedge clk);
      iv[k] = 1'b0;
      ordy = 1'b1;
      @(posedge clk);
      #1;
      check("drop_valid", 64'(ov[k]), 64'd0);
      check("ready_again", 64'(rdy[k]), 64'd1);
      if (stall > 0) begin
         repeat (10) @(posedge clk);
         #1;
         check("stall_pulse_ignored", 64'(ov[k]), 64'd0);
         check("stall_pulse_ready", 64'(rdy[k]), 64'd1);
      end
   endtask

   initial begin
      int ghost;
      logic [63:0] ra, rb;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) iv[k] = 1'b0;
      a_s = '0; b_s = '0; sa_s = 1'b0; sb_s = 1'b0; hi_s = 1'b0; tag_s = '0; ordy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("reset_in_ready", 64'(rdy[k]), 64'd1);
         check("reset_out_valid", 64'(ov[k]), 64'd0);
         check("reset_result", res[k], 64'd0);
         check("reset_tag", 64'(tg[k]), 64'd0);
      end

      // unsigned 2^16 * 2^16
      do_op(0, 64'h0001_0000, 64'h0001_0000, 1'b0, 1'b0, 1'b0, 5'h13, 0);
      check("t1_lo_const", res[0], 64'h0);
      do_op(0, 64'h0001_0000, 64'h0001_0000, 1'b0, 1'b0, 1'b1, 5'h13, 0);
      check("t1_hi_const", res[0], 64'h1);
      // -1 * 2, signed and unsigned
      do_op(0, 64'hFFFF_FFFF, 64'h2, 1'b1, 1'b1, 1'b1, 5'h02, 0);
      check("t2_s_hi_const", res[0], 64'hFFFF_FFFF);
      do_op(0, 64'hFFFF_FFFF, 64'h2, 1'b1, 1'b1, 1'b0, 5'h03, 0);
      check("t2_s_lo_const", res[0], 64'hFFFF_FFFE);
      do_op(0, 64'hFFFF_FFFF, 64'h2, 1'b0, 1'b0, 1'b1, 5'h04, 0);
      check("t2_u_hi_const", res[0], 64'h1);
      do_op(0, 64'hFFFF_FFFF, 64'h2, 1'b0, 1'b0, 1'b0, 5'h05, 0);
      // most negative times all-ones, mixed and fully signed
      do_op(0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 5'h06, 0);
      check("t3_mix_hi_const", res[0], 64'h8000_0000);
      do_op(0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'h07, 0);
      do_op(0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 5'h08, 0);
      check("t3_s_hi_const", res[0], 64'h0);
      do_op(0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 5'h09, 0);
      check("t3_s_lo_const", res[0], 64'h8000_0000);

      // consumer stall for 5 cycles with an in_valid pulse during it
      do_op(0, 64'h1234_5678, 64'h9ABC_DEF0, 1'b1, 1'b0, 1'b1, 5'h0A, 5);

      // reset three edges after acceptance aborts the operation
      @(negedge clk);
      a_s = 64'd7; b_s = 64'd9; sa_s = 1'b0; sb_s = 1'b0; hi_s = 1'b0; tag_s = 5'h0B;
      iv[0] = 1'b1;
      @(posedge clk);
      #1;
      iv[0] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_in_ready", 64'(rdy[0]), 64'd1);
      check("abort_out_valid", 64'(ov[0]), 64'd0);
      ghost = 0;
      for (int j = 0; j < 20; j++) begin
         @(posedge clk);
         #1;
         if (ov[0]) ghost++;
      end
      check("abort_no_result", 64'(ghost), 64'd0);
      do_op(0, 64'd3, 64'd5, 1'b0, 1'b0, 1'b0, 5'h0C, 0);
      check("abort_then_3x5", res[0], 64'd15);

      // 16-bit instance
      do_op(1, 64'hFFFF, 64'hFFFF, 1'b0, 1'b0, 1'b1, 5'h0D, 0);
      check("w16_hi_const", res[1], 64'hFFFE);
      do_op(1, 64'hFFFF, 64'hFFFF, 1'b0, 1'b0, 1'b0, 5'h0E, 0);
      check("w16_lo_const", res[1], 64'h0001);
      do_op(1, 64'h8000, 64'h8000, 1'b1, 1'b1, 1'b1, 5'h0F, 0);

      // 64-bit random sweep with corner operands mixed in
      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 4))
            0:       ra = 64'h8000_0000_0000_0000;
            1:       ra = '1;
            default: ra = {$urandom, $urandom};
         endcase
         case ($urandom_range(0, 4))
            0:       rb = 64'h8000_0000_0000_0000;
            1:       rb = '1;
            default: rb = {$urandom, $urandom};
         endcase
         do_op(2, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 0);
      end

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
